// File: rtl/ipsxe_fft_pkg.sv
// Shared definitions for the FFT xk capture path: capture-state encoding,
// tuser field layout and the bit-reverse helper used for index checking.
package ipsxe_fft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int TUSER_IDX_LSB = 0;
    localparam int BLK_EXP_W     = 8;

    // blk_exp occupies the top BLK_EXP_W bits of tuser
    function automatic int tuser_exp_msb(input int user_width);
        return user_width - 1;
    endfunction

    function automatic logic [15:0] bit_rev(input logic [15:0] v, input int bits);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < bits) r[bits-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ipsxe_fft_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read-first
// read port, both qualified by a common clock enable.
module ipsxe_fft_capture_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; both ports use
    // non-blocking writes, which is what gives read-first on an address clash.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ipsxe_fft_xk_capture.sv
// Captures one FFT output frame from the xk AXI4-Stream into RAM by tuser bin
// index, checking length, index order and block-exponent consistency.
module ipsxe_fft_xk_capture
    import ipsxe_fft_pkg::*;
#(
    parameter int LOG2_FFT_LEN  = 8,
    parameter int DATAOUT_WIDTH = 32,
    parameter int USER_WIDTH    = 16,
    parameter int OUTPUT_ORDER  = 1
) (
    input  logic                       i_aclk,
    input  logic                       i_rst,
    input  logic                       i_aclken,
    input  logic                       i_arm,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]      i_axi4s_data_tuser,
    input  logic                       i_rd_en,
    input  logic [LOG2_FFT_LEN-1:0]    i_rd_addr,
    output logic                       o_rd_valid,
    output logic [2*DATAOUT_WIDTH-1:0] o_rd_data,
    output logic [BLK_EXP_W-1:0]       o_blk_exp,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_len_err,
    output logic                       o_idx_err,
    output logic                       o_exp_err,
    output logic [15:0]                o_frame_cnt
);

    localparam int DW      = 2 * DATAOUT_WIDTH;
    localparam int CW      = LOG2_FFT_LEN + 1;
    localparam int EXP_MSB = tuser_exp_msb(USER_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'((2**LOG2_FFT_LEN) - 1);

    cap_state_t               state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [BLK_EXP_W-1:0]     blk_exp, blk_exp_nxt;
    logic                     len_err, len_err_nxt;
    logic                     idx_err, idx_err_nxt;
    logic                     exp_err, exp_err_nxt;
    logic [15:0]              frame_cnt, frame_cnt_nxt;
    logic                     wr_en;
    logic                     rd_valid;
    logic [DW-1:0]            ram_q;
    logic [LOG2_FFT_LEN-1:0]  beat_idx, exp_idx;
    logic [BLK_EXP_W-1:0]     beat_exp;

    assign beat_idx = i_axi4s_data_tuser[TUSER_IDX_LSB +: LOG2_FFT_LEN];
    assign beat_exp = i_axi4s_data_tuser[EXP_MSB -: BLK_EXP_W];
    assign exp_idx  = (OUTPUT_ORDER != 0) ? cnt[LOG2_FFT_LEN-1:0]
                                          : LOG2_FFT_LEN'(bit_rev(16'(cnt), LOG2_FFT_LEN));

    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        blk_exp_nxt   = blk_exp;
        len_err_nxt   = len_err;
        idx_err_nxt   = idx_err;
        exp_err_nxt   = exp_err;
        frame_cnt_nxt = frame_cnt;
        wr_en         = 1'b0;

        // arm always wins over a coincident beat, including mid-frame aborts
        if (i_arm) begin
            state_nxt   = ARMED;
            cnt_nxt     = '0;
            blk_exp_nxt = '0;
            len_err_nxt = 1'b0;
            idx_err_nxt = 1'b0;
            exp_err_nxt = 1'b0;
        end else if (i_axi4s_data_tvalid) begin
            unique case (state)
                ARMED: begin
                    wr_en       = 1'b1;
                    blk_exp_nxt = beat_exp;
                    cnt_nxt     = CW'(1);
                    state_nxt   = CAPTURE;
                    if (i_axi4s_data_tlast) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = DONE;
                    end
                end
                CAPTURE: begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                    if (beat_idx != exp_idx) idx_err_nxt = 1'b1;
                    if (beat_exp != blk_exp) exp_err_nxt = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt     = DONE;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        if (!i_axi4s_data_tlast) len_err_nxt = 1'b1;
                    end else if (i_axi4s_data_tlast) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            blk_exp   <= '0;
            len_err   <= 1'b0;
            idx_err   <= 1'b0;
            exp_err   <= 1'b0;
            frame_cnt <= '0;
            rd_valid  <= 1'b0;
        end else if (i_aclken) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            blk_exp   <= blk_exp_nxt;
            len_err   <= len_err_nxt;
            idx_err   <= idx_err_nxt;
            exp_err   <= exp_err_nxt;
            frame_cnt <= frame_cnt_nxt;
            rd_valid  <= i_rd_en;
        end
    end

    ipsxe_fft_capture_ram #(
        .ADDR_W (LOG2_FFT_LEN),
        .DATA_W (DW)
    ) u_ram (
        .clk     (i_aclk),
        .ce      (i_aclken),
        .wr_en   (wr_en & ~i_rst),
        .wr_addr (beat_idx),
        .wr_data (i_axi4s_data_tdata),
        .rd_en   (i_rd_en),
        .rd_addr (i_rd_addr),
        .rd_data (ram_q)
    );

    // read data is masked so the un-reset RAM output never leaks out
    assign o_rd_valid  = rd_valid;
    assign o_rd_data   = rd_valid ? ram_q : '0;
    assign o_blk_exp   = blk_exp;
    assign o_busy      = (state == ARMED) || (state == CAPTURE);
    assign o_done      = (state == DONE);
    assign o_len_err   = len_err;
    assign o_idx_err   = idx_err;
    assign o_exp_err   = exp_err;
    assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_ipsxe_fft_xk_capture.sv
// Directed bench for ipsxe_fft_xk_capture: a natural-order and a bit-reversed
// instance share one stimulus stream; reads are checked by a scoreboard monitor.
module tb_ipsxe_fft_xk_capture;

    logic        clk;
    logic        rst;
    logic        aclken;
    logic        arm;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [15:0] tuser;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic        rd_valid_a, rd_valid_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [7:0]  blk_exp_a, blk_exp_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        len_err_a, len_err_b, idx_err_a, idx_err_b, exp_err_a, exp_err_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    ipsxe_fft_xk_capture #(.LOG2_FFT_LEN(8), .DATAOUT_WIDTH(32), .USER_WIDTH(16), .OUTPUT_ORDER(1)) dut_a (
        .i_aclk(clk), .i_rst(rst), .i_aclken(aclken), .i_arm(arm),
        .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
        .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_valid(rd_valid_a), .o_rd_data(rd_data_a), .o_blk_exp(blk_exp_a),
        .o_busy(busy_a), .o_done(done_a), .o_len_err(len_err_a),
        .o_idx_err(idx_err_a), .o_exp_err(exp_err_a), .o_frame_cnt(frame_cnt_a)
    );

    ipsxe_fft_xk_capture #(.LOG2_FFT_LEN(8), .DATAOUT_WIDTH(32), .USER_WIDTH(16), .OUTPUT_ORDER(0)) dut_b (
        .i_aclk(clk), .i_rst(rst), .i_aclken(aclken), .i_arm(arm),
        .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
        .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_valid(rd_valid_b), .o_rd_data(rd_data_b), .o_blk_exp(blk_exp_b),
        .o_busy(busy_b), .o_done(done_b), .o_len_err(len_err_b),
        .o_idx_err(idx_err_b), .o_exp_err(exp_err_b), .o_frame_cnt(frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bin_val(input int k, input int salt);
        return {32'(k + 1000 + salt), 32'(k + salt)};
    endfunction

    function automatic int bitrev8(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
        return r;
    endfunction

    // both instances see identical beats, so only idx_err differs between them
    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic len, input logic idx_a, input logic idx_b,
                                input logic ee, input logic [7:0] bexp, input logic [15:0] fc);
        check($sformatf("%s.busy_a", tag), busy_a, busy);
        check($sformatf("%s.busy_b", tag), busy_b, busy);
        check($sformatf("%s.done_a", tag), done_a, done);
        check($sformatf("%s.done_b", tag), done_b, done);
        check($sformatf("%s.len_a", tag), len_err_a, len);
        check($sformatf("%s.len_b", tag), len_err_b, len);
        check($sformatf("%s.idx_a", tag), idx_err_a, idx_a);
        check($sformatf("%s.idx_b", tag), idx_err_b, idx_b);
        check($sformatf("%s.exp_a", tag), exp_err_a, ee);
        check($sformatf("%s.exp_b", tag), exp_err_b, ee);
        check($sformatf("%s.blk_a", tag), blk_exp_a, bexp);
        check($sformatf("%s.blk_b", tag), blk_exp_b, bexp);
        check($sformatf("%s.fcnt_a", tag), frame_cnt_a, fc);
        check($sformatf("%s.fcnt_b", tag), frame_cnt_b, fc);
    endtask

    task automatic check_reset(input string tag);
        check_status(tag, 0, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        check($sformatf("%s.rdv_a", tag), rd_valid_a, 0);
        check($sformatf("%s.rdv_b", tag), rd_valid_b, 0);
        check($sformatf("%s.rdd_a", tag), rd_data_a, 64'd0);
        check($sformatf("%s.rdd_b", tag), rd_data_b, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic drive_beat(input int idx, input logic last, input logic [7:0] bexp,
                              input int salt, input bit gated);
        tvalid = 1'b1;
        tlast  = last;
        tdata  = bin_val(idx, salt);
        tuser  = {bexp, 8'(idx)};
        if (gated) begin
            aclken = 1'b0;
            repeat (2) tick();
            aclken = 1'b1;
        end
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input bit br, input int first, input int count, input int last_at,
                              input int chg_at, input int salt, input bit gated);
        for (int i = first; i < first + count; i++) begin
            drive_beat(br ? bitrev8(i) : i, (i == last_at),
                       (chg_at >= 0 && i >= chg_at) ? 8'd4 : 8'd3, salt, gated);
        end
    endtask

    task automatic do_read(input int addr, input logic [63:0] exp);
        rd_addr = 8'(addr);
        rd_en   = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    // monitor: every presented read result is matched against the scoreboard
    always @(negedge clk) begin
        if (rd_valid_a || rd_valid_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected valid_a=%0b valid_b=%0b with no read outstanding",
                         rd_valid_a, rd_valid_b);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("rd_valid_a", rd_valid_a, 1);
                check("rd_valid_b", rd_valid_b, 1);
                check("rd_data_a", rd_data_a, e);
                check("rd_data_b", rd_data_b, e);
            end
        end
    end

    initial begin
        rst = 1'b1; aclken = 1'b1; arm = 1'b0; tvalid = 1'b0; tdata = '0;
        tlast = 1'b0; tuser = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("reset");

        send_frame(0, 0, 3, -1, -1, 0, 0);
        check_status("idle_ignore", 0, 0, 0, 0, 0, 0, 8'd0, 16'd0);

        pulse_arm();
        check_status("armed", 1, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        send_frame(0, 0, 256, 255, -1, 0, 0);
        check_status("nat_frame", 0, 1, 0, 0, 1, 0, 8'd3, 16'd1);
        do_read(37, 64'h0000040D_00000025);
        do_read(0, bin_val(0, 0));
        do_read(255, bin_val(255, 0));
        tick();
        check("rd_valid_idle", rd_valid_a, 0);

        pulse_arm();
        send_frame(1, 0, 256, 255, -1, 0, 0);
        check_status("br_frame", 0, 1, 0, 1, 0, 0, 8'd3, 16'd2);
        do_read(1, bin_val(1, 0));
        do_read(128, bin_val(128, 0));

        // read of bin 10 in the same cycle that bin 10 is rewritten returns old data
        pulse_arm();
        send_frame(0, 0, 10, -1, -1, 5, 0);
        rd_addr = 8'd10;
        rd_en   = 1'b1;
        exp_q.push_back(bin_val(10, 0));
        drive_beat(10, 1'b0, 8'd3, 5, 0);
        rd_en = 1'b0;
        send_frame(0, 11, 245, 255, -1, 5, 0);
        check_status("rd_first", 0, 1, 0, 0, 1, 0, 8'd3, 16'd3);
        do_read(10, bin_val(10, 5));

        pulse_arm();
        send_frame(0, 0, 100, 99, -1, 0, 0);
        check_status("early_tlast", 0, 1, 1, 0, 1, 0, 8'd3, 16'd3);

        pulse_arm();
        send_frame(0, 0, 256, -1, -1, 0, 0);
        check_status("no_tlast", 0, 1, 1, 0, 1, 0, 8'd3, 16'd4);

        pulse_arm();
        send_frame(0, 0, 256, 255, 50, 0, 0);
        check_status("exp_chg", 0, 1, 0, 0, 1, 1, 8'd3, 16'd5);
        pulse_arm();
        check_status("rearm", 1, 0, 0, 0, 0, 0, 8'd0, 16'd5);

        send_frame(0, 0, 256, 255, -1, 7, 1);
        check_status("gated", 0, 1, 0, 0, 1, 0, 8'd3, 16'd6);
        do_read(0, bin_val(0, 7));
        do_read(100, bin_val(100, 7));
        do_read(255, bin_val(255, 7));

        // arm coincides with beat 120: frame restarts and that beat is dropped
        pulse_arm();
        send_frame(0, 0, 120, -1, -1, 0, 0);
        tvalid = 1'b1;
        tdata  = bin_val(120, 3);
        tuser  = {8'd3, 8'd120};
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
        tvalid = 1'b0;
        check_status("arm_abort", 1, 0, 0, 0, 0, 0, 8'd0, 16'd6);
        do_read(120, bin_val(120, 7));
        send_frame(0, 0, 256, 255, -1, 9, 0);
        check_status("restart", 0, 1, 0, 0, 1, 0, 8'd3, 16'd7);
        do_read(200, bin_val(200, 9));

        pulse_arm();
        send_frame(0, 0, 50, -1, -1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("mid_reset");
        send_frame(0, 0, 5, -1, -1, 0, 0);
        check_status("post_reset", 0, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        pulse_arm();
        check_status("post_reset_arm", 1, 0, 0, 0, 0, 0, 8'd0, 16'd0);

        repeat (3) tick();
        check("rd_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipsxe_fft_xk_capture.md
Name: ipsxe_fft_xk_capture

Overview:
- AXI4-Stream sink on the FFT result (xk) side: captures one complete output frame of the FFT wrapper into on-chip RAM, indexed by the frequency index carried in tuser.
- Exposes a single-cycle-latency random read port, so a host/debug bridge can read bins back after the onboard test.
- Checks frame length, index order and block-exponent consistency on the fly.
- Sits beside ipsxe_fft_frame_chk on the same xk bus, as the data-retaining consumer.

Parameters:
LOG2_FFT_LEN, 8, log2 of transform length N; RAM depth 2**LOG2_FFT_LEN
DATAOUT_WIDTH, 32, byte-padded width of one real or imaginary component in tdata
USER_WIDTH, 16, tuser width
OUTPUT_ORDER, 1, 1 = natural order expected, 0 = bit-reversed order expected

Ports:
i_aclk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_aclken  in  1  clock enable; when low, no state, counter or RAM update
i_arm  in  1  pulse: clear status and wait for next frame
i_axi4s_data_tvalid  in  1  xk beat valid (no tready; sink always accepts)
i_axi4s_data_tdata  in  2*DATAOUT_WIDTH  [DATAOUT_WIDTH-1:0] real, upper half imag
i_axi4s_data_tlast  in  1  last beat of frame
i_axi4s_data_tuser  in  USER_WIDTH  [LOG2_FFT_LEN-1:0] bin index, [USER_WIDTH-1:USER_WIDTH-8] blk_exp
i_rd_en  in  1  read request
i_rd_addr  in  LOG2_FFT_LEN  bin to read
o_rd_valid  out  1  read data valid
o_rd_data  out  2*DATAOUT_WIDTH  stored {imag, real}
o_blk_exp  out  8  blk_exp latched from first beat
o_busy  out  1  state is ARMED or CAPTURE
o_done  out  1  state is DONE
o_len_err  out  1  early tlast, or missing tlast at beat N-1
o_idx_err  out  1  tuser index differs from expected index
o_exp_err  out  1  blk_exp changed within frame
o_frame_cnt  out  16  completed-frame count, wraps at 2**16

Behaviour:
- Reset: state IDLE; all outputs 0; beat counter 0. RAM contents are not reset.
- State IDLE: i_arm -> ARMED. Beats are ignored.
- State ARMED: i_arm clears o_len_err, o_idx_err, o_exp_err, o_blk_exp and the beat counter.
  - First beat (tvalid & aclken) is written; blk_exp is latched; counter becomes 1; state -> CAPTURE.
  - If that beat also carries tlast and N>1: o_len_err=1, state -> DONE.
- State CAPTURE: each accepted beat writes tdata at RAM[tuser index], then counter+1.
  - Expected index = counter (OUTPUT_ORDER=1) or bit-reverse(counter, LOG2_FFT_LEN bits) (OUTPUT_ORDER=0). Mismatch sets o_idx_err (sticky); the write still goes to the tuser index.
  - blk_exp different from the latched value sets o_exp_err (sticky).
  - Beat with counter==N-1: state -> DONE; o_frame_cnt+1. If tlast is absent on this beat, set o_len_err.
  - tlast with counter<N-1: o_len_err=1, state -> DONE; o_frame_cnt is not incremented.
- State DONE: holds data and flags. Further beats are ignored. i_arm -> ARMED.
- i_arm in CAPTURE: aborts the frame and re-enters ARMED (flags cleared). o_frame_cnt is not incremented.
- i_arm coincident with a beat in ARMED/CAPTURE: the arm wins and the beat is dropped.
- Flags and o_blk_exp update one cycle after the triggering beat. o_done rises the cycle after the final write.
- Read port:
  - o_rd_data / o_rd_valid are valid exactly 1 cycle after i_rd_en. Reads work in all states and are gated by i_aclken.
  - Same-address read/write in one cycle returns old data (read-first).
  - o_rd_valid=0 whenever no read was issued the previous enabled cycle.
- Widths: the counter is LOG2_FFT_LEN+1 bits to avoid wrap at N.

Decomposition:
- Shared package ipsxe_fft_pkg holds: state encoding constants (IDLE, ARMED, CAPTURE, DONE), tuser field offsets (index LSB, blk_exp MSB), and the bit-reverse function.
- One sub-module: ipsxe_fft_capture_ram.
  - Simple dual-port, 2**LOG2_FFT_LEN x 2*DATAOUT_WIDTH.
  - Write port and registered read port, read-first, with clock enable.

Test Plan:
- N=256, natural order, arm, then 256 beats with tdata={idx+1000, idx}, tuser idx 0..255, tlast on beat 255 -> o_done=1, all errors 0, o_frame_cnt=1; reading addr 37 returns {1037,37} one cycle after i_rd_en.
- OUTPUT_ORDER=0, indices sent in bit-reversed order (0,128,64,...) -> o_idx_err=0, RAM[k] holds bin k; resending in natural order -> o_idx_err=1.
- tlast on beat 99 -> o_len_err=1, o_done=1, o_frame_cnt unchanged; full frame without tlast -> o_len_err=1, o_frame_cnt+1.
- blk_exp=3 on beat 0 and 4 on beat 50 -> o_blk_exp=3, o_exp_err=1; re-arm -> flags 0, o_busy=1.
- i_aclken toggling 1-of-3 during a frame -> identical RAM contents and flags to the full-rate run; i_arm at beat 120 -> restart, and the next 256 beats complete cleanly.
- i_rst asserted mid-CAPTURE -> state IDLE, all outputs 0; subsequent beats are ignored until i_arm.
